// File: rtl/tdm_demux_2ch_if.sv
// Bundle of the TDM receive link: the serial input side and the
// per-channel parallel outputs of the demultiplexer.
interface tdm_demux_2ch_if #(
  parameter int WIDTH = 8
);
  logic             din;
  logic             din_valid;
  logic             sync;
  logic [WIDTH-1:0] ch0_data;
  logic             ch0_valid;
  logic [WIDTH-1:0] ch1_data;
  logic             ch1_valid;
  logic             locked;
  logic             frame_err;

  // Link driver / consumer side.
  modport master (
    output din, din_valid, sync,
    input  ch0_data, ch0_valid, ch1_data, ch1_valid, locked, frame_err
  );

  // Demultiplexer side.
  modport slave (
    input  din, din_valid, sync,
    output ch0_data, ch0_valid, ch1_data, ch1_valid, locked, frame_err
  );
endinterface

// File: rtl/tdm_demux_2ch.sv
// Two-channel TDM demultiplexer: delineates frames on the sync marker and
// deserializes the ch0 and ch1 slots (MSB first) into parallel words, each
// with a one-cycle valid strobe. Loss of alignment pulses frame_err.
module tdm_demux_2ch #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  tdm_demux_2ch_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] CH0  = 2'd1;
  localparam logic [1:0] CH1  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] ch0_data_q;
  logic [WIDTH-1:0] ch1_data_q;
  logic             ch0_valid_q;
  logic             ch1_valid_q;
  logic             locked_q;
  logic             frame_err_q;

  // Shift register contents after taking the current bit; also the
  // completed word when the last bit of a slot arrives.
  logic [WIDTH-1:0] sr_next;
  assign sr_next = {sr[WIDTH-2:0], bus.din};

  // First bit of a frame position: the only place sync is allowed.
  logic at_frame_start;
  assign at_frame_start = (state == CH0) && (cnt == '0);

  // Frame delineation, deserialization and alignment supervision.
  // NOTE: every register here uses non-blocking assignment so all updates
  // take effect together at the edge; the strobes default low each cycle and
  // are only raised by the word-complete or violation branches below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      cnt         <= '0;
      sr          <= '0;
      ch0_data_q  <= '0;
      ch1_data_q  <= '0;
      ch0_valid_q <= 1'b0;
      ch1_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ch0_valid_q <= 1'b0;
      ch1_valid_q <= 1'b0;
      frame_err_q <= 1'b0;

      if (bus.din_valid) begin
        if (state == HUNT) begin
          // Sync-less bits are dropped until a frame start is seen.
          if (bus.sync) begin
            sr    <= sr_next;
            cnt   <= CNT_ONE;
            state <= CH0;
          end
        end else if (at_frame_start && locked_q && !bus.sync) begin
          // Expected marker missing: alignment lost, drop the bit.
          frame_err_q <= 1'b1;
          locked_q    <= 1'b0;
          cnt         <= '0;
          state       <= HUNT;
        end else if (bus.sync && !at_frame_start) begin
          // Marker in the wrong place: abandon the partial word and
          // treat this bit as the first bit of a new frame.
          frame_err_q <= 1'b1;
          locked_q    <= 1'b0;
          sr          <= sr_next;
          cnt         <= CNT_ONE;
          state       <= CH0;
        end else begin
          sr <= sr_next;
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (state == CH0) begin
              ch0_data_q  <= sr_next;
              ch0_valid_q <= 1'b1;
              state       <= CH1;
            end else begin
              ch1_data_q  <= sr_next;
              ch1_valid_q <= 1'b1;
              locked_q    <= 1'b1;
              state       <= CH0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      end
    end
  end

  assign bus.ch0_data  = ch0_data_q;
  assign bus.ch0_valid = ch0_valid_q;
  assign bus.ch1_data  = ch1_data_q;
  assign bus.ch1_valid = ch1_valid_q;
  assign bus.locked    = locked_q;
  assign bus.frame_err = frame_err_q;

endmodule
